// File: rtl/jericalla_pkg.sv
// Shared definitions for the Jericalla front end and control unit:
// opcode values, instruction field positions and the fetch/issue FSM states.
package jericalla_pkg;

    // Opcode encoding (bits [15:13] of every instruction word)
    localparam int         OP_W     = 3;
    localparam logic [2:0] OP_ALU0  = 3'b000;
    localparam logic [2:0] OP_ALU1  = 3'b001;
    localparam logic [2:0] OP_ALU2  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // Instruction word layout; bit 0 is reserved
    localparam int INSTR_W = 16;
    localparam int OP_LSB  = 13;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 5;
    localparam int RS2_LSB = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_MEM,
        ST_HALT
    } state_e;

    // Opcodes that actually execute (ALU and memory ops)
    function automatic logic is_exec_op(input logic [2:0] op);
        return (op == OP_ALU0) || (op == OP_ALU1) || (op == OP_ALU2) ||
               (op == OP_STORE) || (op == OP_LOAD);
    endfunction

    // Opcodes that must wait for the data-RAM access to finish
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_STORE) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: async clear, synchronous load-zero and increment.
// Increment wraps naturally modulo 2^PC_W.
module pc_reg #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [PC_W-1:0] pc_o
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Next pc: load-zero has priority over increment
    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (inc_i) begin
            pc_d = pc_q + PC_ONE;
        end
    end

    // PC state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_issue.sv
// Jericalla front end: fetches instruction words over a req/ack handshake,
// splits them into opcode and register fields, and issues one instruction
// per issue_valid pulse, stalling memory ops until the data RAM reports done.
module instr_fetch_issue
    import jericalla_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int RA_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [2:0]      inst,
    output logic [RA_W-1:0] rd_addr,
    output logic [RA_W-1:0] rs1_addr,
    output logic [RA_W-1:0] rs2_addr,
    output logic            issue_valid,
    input  logic            mem_done,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    state_e state_q;
    state_e state_d;

    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] op_d;
    logic [RA_W-1:0] rd_q;
    logic [RA_W-1:0] rd_d;
    logic [RA_W-1:0] rs1_q;
    logic [RA_W-1:0] rs1_d;
    logic [RA_W-1:0] rs2_q;
    logic [RA_W-1:0] rs2_d;

    logic            capture;
    logic            pc_clr;
    logic            pc_inc;
    logic [PC_W-1:0] pc;
    logic [OP_W-1:0] ack_op;

    // Reserved bit 0 of the instruction word carries no meaning
    logic unused_rsvd;
    assign unused_rsvd = imem_rdata[0];

    assign ack_op = imem_rdata[OP_LSB +: OP_W];

    pc_reg #(
        .PC_W (PC_W)
    ) u_pc_reg (
        .clk   (clk),
        .rst   (rst),
        .clr_i (pc_clr),
        .inc_i (pc_inc),
        .pc_o  (pc)
    );

    // Next-state and output decode. The cycle after every non-HALT capture
    // is spent in ST_ISSUE: legal words issue there, illegal words raise
    // the illegal pulse instead, which also keeps imem_req low for that cycle.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        pc_clr      = 1'b0;
        pc_inc      = 1'b0;
        imem_req    = 1'b0;
        issue_valid = 1'b0;
        illegal     = 1'b0;
        busy        = 1'b1;
        halted      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    pc_clr  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    capture = 1'b1;
                    state_d = (ack_op == OP_HALT) ? ST_HALT : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!is_exec_op(op_q)) begin
                    illegal = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    issue_valid = 1'b1;
                    if (is_mem_op(op_q) && !mem_done) begin
                        state_d = ST_WAIT_MEM;
                    end else begin
                        pc_inc  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (mem_done) begin
                    pc_inc  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Field next values: load on the ack cycle, otherwise hold so the
    // control unit sees stable fields between issues
    always_comb begin
        op_d  = op_q;
        rd_d  = rd_q;
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        if (capture) begin
            op_d  = ack_op;
            rd_d  = imem_rdata[RD_LSB +: RA_W];
            rs1_d = imem_rdata[RS1_LSB +: RA_W];
            rs2_d = imem_rdata[RS2_LSB +: RA_W];
        end
    end

    // Field registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            op_q  <= op_d;
            rd_q  <= rd_d;
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
        end
    end

    assign imem_addr = pc;
    assign inst      = op_q;
    assign rd_addr   = rd_q;
    assign rs1_addr  = rs1_q;
    assign rs2_addr  = rs2_q;

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench for instr_fetch_issue: directed scenarios plus a
// randomized instruction stream checked against an instruction-level model.
module tb_instr_fetch_issue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (PC_W = 8)
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [2:0]  inst;
    logic [3:0]  rd_addr;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic        issue_valid;
    logic        mem_done;
    logic        busy;
    logic        halted;
    logic        illegal;

    // Small DUT (PC_W = 2) for the wrap check
    logic        rst2;
    logic        start2;
    logic        imem_req2;
    logic [1:0]  imem_addr2;
    logic        imem_ack2;
    logic [15:0] imem_rdata2;
    logic [2:0]  inst2;
    logic [3:0]  rd_addr2;
    logic [3:0]  rs1_addr2;
    logic [3:0]  rs2_addr2;
    logic        issue_valid2;
    logic        mem_done2;
    logic        busy2;
    logic        halted2;
    logic        illegal2;

    int n_vec = 0;
    int n_err = 0;

    // Status bundle: {imem_req, issue_valid, illegal, busy, halted}
    logic [4:0] st;
    assign st = {imem_req, issue_valid, illegal, busy, halted};

    localparam logic [4:0] ST_IDLE_V  = 5'b00000;
    localparam logic [4:0] ST_FETCH_V = 5'b10010;
    localparam logic [4:0] ST_ISSUE_V = 5'b01010;
    localparam logic [4:0] ST_WAIT_V  = 5'b00010;
    localparam logic [4:0] ST_ILL_V   = 5'b00110;
    localparam logic [4:0] ST_HALT_V  = 5'b00001;

    instr_fetch_issue #(
        .PC_W (8),
        .RA_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .rd_addr     (rd_addr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .issue_valid (issue_valid),
        .mem_done    (mem_done),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal)
    );

    instr_fetch_issue #(
        .PC_W (2),
        .RA_W (4)
    ) dut2 (
        .clk         (clk),
        .rst         (rst2),
        .start       (start2),
        .imem_req    (imem_req2),
        .imem_addr   (imem_addr2),
        .imem_ack    (imem_ack2),
        .imem_rdata  (imem_rdata2),
        .inst        (inst2),
        .rd_addr     (rd_addr2),
        .rs1_addr    (rs1_addr2),
        .rs2_addr    (rs2_addr2),
        .issue_valid (issue_valid2),
        .mem_done    (mem_done2),
        .busy        (busy2),
        .halted      (halted2),
        .illegal     (illegal2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        imem_ack   = 1'b0;
        mem_done   = 1'b0;
        imem_rdata = 16'h0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (st !== ST_IDLE_V) begin n_err++; $display("FAIL reset_status got=%b exp=%b", st, ST_IDLE_V); end
        n_vec++; if (imem_addr !== 8'd0) begin n_err++; $display("FAIL reset_addr got=%0d exp=0", imem_addr); end
        n_vec++; if ({inst, rd_addr, rs1_addr, rs2_addr} !== 15'd0) begin n_err++;
            $display("FAIL reset_fields got=%h exp=0", {inst, rd_addr, rs1_addr, rs2_addr}); end
        // start is the only way out of IDLE; ack/mem_done alone do nothing
        imem_ack = 1'b1; mem_done = 1'b1;
        tick();
        imem_ack = 1'b0; mem_done = 1'b0;
        n_vec++; if (st !== ST_IDLE_V) begin n_err++; $display("FAIL idle_ignores_inputs got=%b exp=%b", st, ST_IDLE_V); end
        $display("test_reset done");
    endtask

    task automatic test_alu_seq();
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (st !== ST_FETCH_V) begin n_err++; $display("FAIL alu_fetch%0d_status got=%b exp=%b", i, st, ST_FETCH_V); end
            n_vec++; if (imem_addr !== 8'(i)) begin n_err++; $display("FAIL alu_fetch%0d_addr got=%0d exp=%0d", i, imem_addr, i); end
            imem_ack   = 1'b1;
            imem_rdata = {3'(i), 13'h0000};
            tick();
            imem_ack = 1'b0;
            n_vec++; if (st !== ST_ISSUE_V) begin n_err++; $display("FAIL alu_issue%0d_status got=%b exp=%b", i, st, ST_ISSUE_V); end
            n_vec++; if (inst !== 3'(i)) begin n_err++; $display("FAIL alu_issue%0d_inst got=%0d exp=%0d", i, inst, i); end
            tick();
        end
        n_vec++; if (st !== ST_FETCH_V || imem_addr !== 8'd3) begin n_err++;
            $display("FAIL alu_next_fetch got=%b/%0d exp=%b/3", st, imem_addr, ST_FETCH_V); end
        $display("test_alu_seq done");
    endtask

    task automatic test_load_wait();
        do_reset();
        do_start();
        // load, rd=A rs1=5 rs2=3, reserved bit set
        imem_ack   = 1'b1;
        imem_rdata = 16'h94A7;
        tick();
        imem_ack = 1'b0;
        mem_done = 1'b0;
        n_vec++; if (st !== ST_ISSUE_V) begin n_err++; $display("FAIL load_issue_status got=%b exp=%b", st, ST_ISSUE_V); end
        n_vec++; if ({inst, rd_addr, rs1_addr, rs2_addr} !== {3'd4, 4'hA, 4'h5, 4'h3}) begin n_err++;
            $display("FAIL load_fields got=%h exp=%h", {inst, rd_addr, rs1_addr, rs2_addr}, {3'd4, 4'hA, 4'h5, 4'h3}); end
        for (int j = 1; j <= 3; j++) begin
            tick();
            n_vec++; if (st !== ST_WAIT_V) begin n_err++; $display("FAIL load_wait%0d_status got=%b exp=%b", j, st, ST_WAIT_V); end
            n_vec++; if (inst !== 3'd4 || rd_addr !== 4'hA) begin n_err++;
                $display("FAIL load_wait%0d_hold got=%0d/%h exp=4/a", j, inst, rd_addr); end
            mem_done = (j == 3);
        end
        tick();
        mem_done = 1'b0;
        n_vec++; if (st !== ST_FETCH_V || imem_addr !== 8'd1) begin n_err++;
            $display("FAIL load_next_fetch got=%b/%0d exp=%b/1", st, imem_addr, ST_FETCH_V); end
        $display("test_load_wait done");
    endtask

    task automatic test_store_fast();
        do_reset();
        do_start();
        imem_ack   = 1'b1;
        imem_rdata = 16'h6000;
        tick();
        imem_ack = 1'b0;
        n_vec++; if (st !== ST_ISSUE_V || inst !== 3'd3) begin n_err++;
            $display("FAIL store_issue got=%b/%0d exp=%b/3", st, inst, ST_ISSUE_V); end
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        n_vec++; if (st !== ST_FETCH_V || imem_addr !== 8'd1) begin n_err++;
            $display("FAIL store_next_fetch got=%b/%0d exp=%b/1", st, imem_addr, ST_FETCH_V); end
        $display("test_store_fast done");
    endtask

    task automatic test_illegal_halt();
        do_reset();
        do_start();
        imem_ack   = 1'b1;
        imem_rdata = 16'hA000;
        tick();
        imem_ack = 1'b0;
        n_vec++; if (st !== ST_ILL_V) begin n_err++; $display("FAIL illegal_pulse got=%b exp=%b", st, ST_ILL_V); end
        tick();
        n_vec++; if (st !== ST_FETCH_V || imem_addr !== 8'd1) begin n_err++;
            $display("FAIL illegal_next_fetch got=%b/%0d exp=%b/1", st, imem_addr, ST_FETCH_V); end
        imem_ack   = 1'b1;
        imem_rdata = 16'hE000;
        tick();
        imem_ack = 1'b0;
        n_vec++; if (st !== ST_HALT_V) begin n_err++; $display("FAIL halt_status got=%b exp=%b", st, ST_HALT_V); end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            imem_ack = 1'($urandom); mem_done = 1'($urandom);
            tick();
            n_vec++; if (st !== ST_HALT_V || imem_addr !== 8'd1) begin n_err++;
                $display("FAIL halt_hold%0d got=%b/%0d exp=%b/1", k, st, imem_addr, ST_HALT_V); end
        end
        imem_ack = 1'b0; mem_done = 1'b0;
        $display("test_illegal_halt done");
    endtask

    task automatic test_wrap();
        rst2 = 1'b1; start2 = 1'b0; imem_ack2 = 1'b0; imem_rdata2 = 16'h0000; mem_done2 = 1'b0;
        tick();
        rst2   = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (imem_req2 !== 1'b1 || imem_addr2 !== 2'(i % 4)) begin n_err++;
                $display("FAIL wrap_fetch%0d got=%b/%0d exp=1/%0d", i, imem_req2, imem_addr2, i % 4); end
            imem_ack2   = 1'b1;
            imem_rdata2 = 16'h2000;
            tick();
            imem_ack2 = 1'b0;
            n_vec++; if (issue_valid2 !== 1'b1) begin n_err++; $display("FAIL wrap_issue%0d got=%b exp=1", i, issue_valid2); end
            tick();
        end
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        do_start();
        imem_ack   = 1'b1;
        imem_rdata = 16'h0000;
        tick();
        imem_ack = 1'b0;
        tick();
        n_vec++; if (imem_addr !== 8'd1) begin n_err++; $display("FAIL midrst_pre_addr got=%0d exp=1", imem_addr); end
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (st !== ST_IDLE_V || imem_addr !== 8'd0) begin n_err++;
            $display("FAIL midrst_async got=%b/%0d exp=%b/0", st, imem_addr, ST_IDLE_V); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            imem_ack   = (k == 2);
            imem_rdata = 16'h0000;
            tick();
            n_vec++; if (st !== ST_IDLE_V) begin n_err++; $display("FAIL midrst_late_ack%0d got=%b exp=%b", k, st, ST_IDLE_V); end
        end
        imem_ack = 1'b0;
        do_start();
        n_vec++; if (st !== ST_FETCH_V || imem_addr !== 8'd0) begin n_err++;
            $display("FAIL midrst_restart got=%b/%0d exp=%b/0", st, imem_addr, ST_FETCH_V); end
        $display("test_reset_mid_fetch done");
    endtask

    // Random instruction stream. The model works per instruction: it tracks
    // the expected pc, and from each fetched word's opcode decides what the
    // following cycles must show (issue, wait for memory, illegal, halt).
    task automatic test_random();
        logic [7:0]  pc_m;
        logic [15:0] word;
        logic [2:0]  op;
        int          d;
        int          w;
        logic        is_mem;
        do_reset();
        do_start();
        pc_m = 8'd0;
        for (int n = 0; n < 300; n++) begin
            d  = $urandom_range(0, 2);
            op = 3'($urandom_range(0, 6));
            if (n == 299) op = 3'b111;
            word   = {op, 13'($urandom)};
            is_mem = (op == 3'd3) || (op == 3'd4);
            for (int k = 0; k < d; k++) begin
                imem_ack = 1'b0; start = 1'($urandom); mem_done = 1'($urandom);
                n_vec++; if (st !== ST_FETCH_V || imem_addr !== pc_m) begin n_err++;
                    $display("FAIL rnd%0d_wait_fetch got=%b/%0d exp=%b/%0d", n, st, imem_addr, ST_FETCH_V, pc_m); end
                tick();
            end
            n_vec++; if (st !== ST_FETCH_V || imem_addr !== pc_m) begin n_err++;
                $display("FAIL rnd%0d_fetch got=%b/%0d exp=%b/%0d", n, st, imem_addr, ST_FETCH_V, pc_m); end
            imem_ack = 1'b1; imem_rdata = word; start = 1'($urandom); mem_done = 1'($urandom);
            tick();
            imem_ack = 1'b0; imem_rdata = 16'($urandom);
            if (op == 3'b111) begin
                n_vec++; if (st !== ST_HALT_V) begin n_err++; $display("FAIL rnd%0d_halt got=%b exp=%b", n, st, ST_HALT_V); end
            end else if (op == 3'b101 || op == 3'b110) begin
                n_vec++; if (st !== ST_ILL_V || inst !== op) begin n_err++;
                    $display("FAIL rnd%0d_illegal got=%b/%0d exp=%b/%0d", n, st, inst, ST_ILL_V, op); end
                imem_ack = 1'($urandom);
                tick();
                pc_m = pc_m + 8'd1;
            end else begin
                n_vec++; if (st !== ST_ISSUE_V) begin n_err++; $display("FAIL rnd%0d_issue got=%b exp=%b", n, st, ST_ISSUE_V); end
                n_vec++; if ({inst, rd_addr, rs1_addr, rs2_addr} !== {word[15:13], word[12:9], word[8:5], word[4:1]}) begin n_err++;
                    $display("FAIL rnd%0d_fields got=%h exp=%h", n, {inst, rd_addr, rs1_addr, rs2_addr},
                             {word[15:13], word[12:9], word[8:5], word[4:1]}); end
                w = is_mem ? $urandom_range(0, 3) : 0;
                if (w == 0) mem_done = is_mem ? 1'b1 : 1'($urandom);
                else        mem_done = 1'b0;
                imem_ack = 1'($urandom);
                tick();
                for (int j = 1; j <= w; j++) begin
                    n_vec++; if (st !== ST_WAIT_V || inst !== op || rd_addr !== word[12:9]) begin n_err++;
                        $display("FAIL rnd%0d_memwait%0d got=%b/%0d/%h exp=%b/%0d/%h", n, j, st, inst, rd_addr,
                                 ST_WAIT_V, op, word[12:9]); end
                    mem_done = (j == w);
                    imem_ack = 1'($urandom);
                    tick();
                end
                pc_m = pc_m + 8'd1;
            end
        end
        start = 1'b0; imem_ack = 1'b0; mem_done = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000; mem_done = 1'b0;
        rst2 = 1'b1; start2 = 1'b0; imem_ack2 = 1'b0; imem_rdata2 = 16'h0000; mem_done2 = 1'b0;
        test_reset();
        test_alu_seq();
        test_load_wait();
        test_store_fast();
        test_illegal_halt();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
